// File: rtl/match_session_ctrl.sv
// Windowed equality-run detector: counts samples whose run of w1==w2 reaches RUN_LEN.
// Latency: one sample per edge after start; z and done are registered, one cycle after the sample.
// Backpressure: results are held in DONE until ack; start is ignored while busy or done.
module match_session_ctrl #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] sample_len,
    input  logic             w1,
    input  logic             w2,
    input  logic             ack,
    output logic             busy,
    output logic             z,
    output logic             done,
    output logic             found,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] first_hit
);

    localparam int RUN_W = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic [RUN_W-1:0] run_q;
    logic [CNT_W-1:0] hit_count_q;
    logic [CNT_W-1:0] first_hit_q;
    logic             found_q;
    logic             z_q;
    logic             busy_q;
    logic             done_q;

    logic [RUN_W-1:0] run_d;
    logic [CNT_W-1:0] hit_count_d;
    logic             hit;
    logic             last_sample;

    // Run saturates at RUN_LEN so every further equal sample is another hit.
    always_comb begin
        run_d = '0;
        if (w1 == w2) begin
            if (run_q == RUN_W'(RUN_LEN))
                run_d = run_q;
            else
                run_d = run_q + RUN_W'(1);
        end
    end

    assign hit         = (run_d == RUN_W'(RUN_LEN));
    assign hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + CNT_W'(1);
    assign last_sample = (idx_q == len_q - CNT_W'(1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            run_q       <= '0;
            hit_count_q <= '0;
            first_hit_q <= '0;
            found_q     <= 1'b0;
            z_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            z_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q       <= sample_len;
                        idx_q       <= '0;
                        run_q       <= '0;
                        hit_count_q <= '0;
                        first_hit_q <= '0;
                        found_q     <= 1'b0;
                        if (sample_len != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    run_q <= run_d;
                    idx_q <= idx_q + CNT_W'(1);
                    z_q   <= hit;
                    if (hit) begin
                        hit_count_q <= hit_count_d;
                        if (!found_q) begin
                            found_q     <= 1'b1;
                            first_hit_q <= idx_q;
                        end
                    end
                    if (last_sample) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign z         = z_q;
    assign done      = done_q;
    assign found     = found_q;
    assign hit_count = hit_count_q;
    assign first_hit = first_hit_q;

endmodule

// File: tb/tb_match_session_ctrl.sv
// Directed bench for match_session_ctrl with hand-computed expected values.
module tb_match_session_ctrl;

    logic       Clock;
    logic       Resetn;
    logic       start;
    logic [7:0] sample_len;
    logic       w1;
    logic       w2;
    logic       ack;
    logic       busy;
    logic       z;
    logic       done;
    logic       found;
    logic [7:0] hit_count;
    logic [7:0] first_hit;

    int checks   = 0;
    int failures = 0;

    match_session_ctrl #(.RUN_LEN(4), .CNT_W(8)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .start      (start),
        .sample_len (sample_len),
        .w1         (w1),
        .w2         (w2),
        .ack        (ack),
        .busy       (busy),
        .z          (z),
        .done       (done),
        .found      (found),
        .hit_count  (hit_count),
        .first_hit  (first_hit)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_done"},  {31'd0, done},  32'd0);
        check({tag, "_z"},     {31'd0, z},     32'd0);
        check({tag, "_found"}, {31'd0, found}, 32'd0);
        check({tag, "_hc"},    {24'd0, hit_count}, 32'd0);
        check({tag, "_fh"},    {24'd0, first_hit}, 32'd0);
    endtask

    // Runs one window; optionally pulses start (with a bogus length) at sample start_at.
    task automatic run_session(input int len, input logic [31:0] w1v, input logic [31:0] w2v,
                               input int start_at, output logic [31:0] zm);
        zm = '0;
        start = 1'b1;
        sample_len = 8'(len);
        step();
        for (int i = 0; i < len; i++) begin
            w1 = w1v[i];
            w2 = w2v[i];
            if (i == start_at) begin
                start = 1'b1;
                sample_len = 8'd2;
            end else begin
                start = 1'b0;
            end
            step();
            zm[i] = z;
            if (i < len - 1) begin
                check($sformatf("busy_s%0d", i), {31'd0, busy}, 32'd1);
                check($sformatf("done_s%0d", i), {31'd0, done}, 32'd0);
            end
        end
        start = 1'b0;
        check("busy_end", {31'd0, busy}, 32'd0);
        check("done_end", {31'd0, done}, 32'd1);
    endtask

    task automatic do_ack(input logic [7:0] exp_hc);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ack_done", {31'd0, done}, 32'd0);
        check("ack_busy", {31'd0, busy}, 32'd0);
        check("ack_z",    {31'd0, z},    32'd0);
        check("ack_hc",   {24'd0, hit_count}, {24'd0, exp_hc});
    endtask

    logic [31:0] zm;

    initial begin
        Resetn = 1'b0;
        start = 1'b0;
        sample_len = '0;
        w1 = 1'b0;
        w2 = 1'b0;
        ack = 1'b0;
        #1;
        check_idle_outputs("reset");
        #9;
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_idle_outputs("idle_quiet");

        // Mixed window: single hit at index 4.
        run_session(8, 32'h76, 32'h57, -1, zm);
        check("mixed_z",     zm, 32'h10);
        check("mixed_hc",    {24'd0, hit_count}, 32'd1);
        check("mixed_fh",    {24'd0, first_hit}, 32'd4);
        check("mixed_found", {31'd0, found}, 32'd1);
        do_ack(8'd1);
        check("mixed_fh_after_ack", {24'd0, first_hit}, 32'd4);

        // All-equal window with a start pulse mid-run that must be ignored.
        run_session(6, 32'h00, 32'h00, 2, zm);
        check("equal_z",     zm, 32'h38);
        check("equal_z_done", {31'd0, z}, 32'd1);
        check("equal_hc",    {24'd0, hit_count}, 32'd3);
        check("equal_fh",    {24'd0, first_hit}, 32'd3);
        check("equal_found", {31'd0, found}, 32'd1);
        do_ack(8'd3);

        // Alternating: never equal.
        run_session(5, 32'h15, 32'h0A, -1, zm);
        check("alt_z",     zm, 32'h0);
        check("alt_hc",    {24'd0, hit_count}, 32'd0);
        check("alt_fh",    {24'd0, first_hit}, 32'd0);
        check("alt_found", {31'd0, found}, 32'd0);
        do_ack(8'd0);

        // Zero-length session, then start ignored while DONE.
        start = 1'b1;
        sample_len = 8'd0;
        step();
        start = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_hc",   {24'd0, hit_count}, 32'd0);
        start = 1'b1;
        sample_len = 8'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("zero_hold%0d_done", i), {31'd0, done}, 32'd1);
            check($sformatf("zero_hold%0d_busy", i), {31'd0, busy}, 32'd0);
            step();
        end
        do_ack(8'd0);
        step();
        check("zero_idle_busy", {31'd0, busy}, 32'd0);
        check("zero_idle_done", {31'd0, done}, 32'd0);

        // Reset asserted before sample 3 of an all-11 window.
        start = 1'b1;
        sample_len = 8'd8;
        w1 = 1'b1;
        w2 = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        Resetn = 1'b0;
        #1;
        check_idle_outputs("midrst");
        step();
        step();
        check_idle_outputs("midrst_hold");
        Resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("post_rst%0d_done", i), {31'd0, done}, 32'd0);
        end

        run_session(4, 32'hF, 32'hF, -1, zm);
        check("after_rst_z",  zm, 32'h8);
        check("after_rst_hc", {24'd0, hit_count}, 32'd1);
        check("after_rst_fh", {24'd0, first_hit}, 32'd3);
        check("after_rst_found", {31'd0, found}, 32'd1);
        do_ack(8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/match_session_ctrl.md
Name: match_session_ctrl

Overview:
- Session controller for the two-input equality-run detector (w1/w2 pair, z asserted after RUN_LEN consecutive w1==w2 samples).
- Contains the run-detection datapath and sequences it over a bounded window of samples launched by start.
- Reports hit count, first-hit index and a found flag through a done/ack handshake, so a host can run repeated detection sessions without manual reset.

Parameters:
- RUN_LEN, 4, consecutive equal samples required for a hit (>=1)
- CNT_W, 8, width of sample length, index and hit counters

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous active-low reset
- start  in  1  launch session; sampled only in IDLE
- sample_len  in  CNT_W  number of samples in session; latched on start
- w1  in  1  detector input 1
- w2  in  1  detector input 2
- ack  in  1  host acknowledges results; sampled only in DONE
- busy  out  1  high in RUN
- z  out  1  registered hit pulse
- done  out  1  high in DONE, results valid
- found  out  1  at least one hit in session
- hit_count  out  CNT_W  number of hit samples
- first_hit  out  CNT_W  0-based sample index of first hit

Behaviour:
- Reset (Resetn=0, asynchronous): state IDLE, all outputs 0, internal run/index counters 0. Effective immediately, including mid-RUN; the session is abandoned with no done.
- States: IDLE, RUN, DONE.
- IDLE, start=1, sample_len!=0:
  - latch sample_len
  - clear run counter, index, hit_count, found, first_hit
  - next state RUN
- IDLE, start=1, sample_len=0: next state DONE with cleared results (zero-length session).
- RUN sampling:
  - One sample of (w1,w2) per rising edge. The first sample is the edge after the start edge.
  - Index runs 0..len-1.
- RUN run counter:
  - w1==w2: run = min(run+1, RUN_LEN), saturating.
  - otherwise: run = 0.
- Hit: a sample whose updated run equals RUN_LEN. Overlapping hits count, so each further equal sample is another hit.
- On each hit:
  - hit_count += 1, saturating at all-ones
  - on the first hit only: found=1, first_hit=index
- z: registered. z=1 for exactly the cycle following each hit sample, including the first DONE cycle if the last sample hits. Otherwise 0.
- Window end: after the edge sampling index len-1, state becomes DONE. busy drops and done rises in that same cycle.
- DONE:
  - hold done, found, hit_count and first_hit stable.
  - ack=1 -> IDLE on the next edge; done clears and results keep their values until the next start.
- start is ignored in RUN and DONE. ack is ignored outside DONE.
- The run counter does not carry across sessions.
- w1/w2 are not sampled in IDLE or DONE.

Test Plan:
- Reset:
  - Resetn=0 at t=0 -> busy=done=z=found=0, hit_count=first_hit=0.
  - Release at 10ns; no activity without start.
- Mixed window, sample_len=8, pairs (w1w2) 01,11,11,00,11,10,11,00:
  - single hit at index 4.
  - z high one cycle after sample 4.
  - done -> hit_count=1, first_hit=4, found=1.
- All equal, sample_len=6, all 00:
  - hits at indices 3,4,5; z high 3 consecutive cycles.
  - hit_count=3, first_hit=3; z still 1 in the first DONE cycle.
- Alternating, sample_len=5, pairs 10,01,10,01,10:
  - z never rises.
  - done -> hit_count=0, found=0, first_hit=0.
- Zero-length and handshake:
  - sample_len=0 start -> done=1 the next cycle, hit_count=0.
  - start pulsed in DONE is ignored; done holds 5 cycles until ack=1, then IDLE.
- Reset mid-session and start while busy:
  - start pulse during RUN is ignored.
  - Resetn=0 at sample 3 of an 8-sample all-11 window -> immediate IDLE, all outputs 0, no done.
  - New session after release with 4×11, sample_len=4 -> hit_count=1, first_hit=3.
